// File: rtl/dat_mem_pkg.sv
// dat_mem_pkg: shared constants and types for the data-memory arbiter
package dat_mem_pkg;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {CLEAR, SERVE} arb_state_t;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/dat_mem_arb_rr_arb2.sv
// rr_arb2: two-input round-robin picker; pointer register lives in the parent
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       next_ptr
);
    // ptr selects the winner only on a tie; a grant hands priority to the other port
    always_comb begin
        gnt[0]   = req[0] & (~req[1] | ~ptr);
        gnt[1]   = req[1] & (~req[0] | ptr);
        next_ptr = |gnt ? gnt[0] : ptr;
    end
endmodule

// File: rtl/dat_mem_arb.sv
// dat_mem_arb: clear sequencer and two-port round-robin arbiter for the data memory
module dat_mem_arb #(
    parameter int AW           = dat_mem_pkg::AW,
    parameter int DW           = dat_mem_pkg::DW,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_rvalid,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out,
    output logic          busy,
    output logic          clr_done
);
    import dat_mem_pkg::*;

    arb_state_t    state_q;
    logic [AW-1:0] clr_cnt_q;
    logic          rr_ptr_q, rr_ptr_d;
    logic [DW-1:0] p0_rdata_q, p1_rdata_q;
    logic          p0_rvalid_q, p1_rvalid_q, clr_done_q;
    logic [1:0]    arb_req, gnt;
    logic          clearing;

    assign clearing = state_q == CLEAR;
    assign arb_req  = (!clearing && !start) ? {p1_req, p0_req} : 2'b00;

    rr_arb2 u_arb (
        .req      (arb_req),
        .ptr      (rr_ptr_q),
        .gnt      (gnt),
        .next_ptr (rr_ptr_d)
    );

    // memory port: the sweep owns it in CLEAR, otherwise the granted requester or idle zeros
    always_comb begin
        mem_wr_en  = clearing | (gnt[1] & p1_we) | (gnt[0] & p0_we);
        mem_addr   = clearing ? clr_cnt_q : gnt[1] ? p1_addr : gnt[0] ? p0_addr : '0;
        mem_dat_in = clearing ? '0 : gnt[1] ? p1_wdata : gnt[0] ? p0_wdata : '0;
    end

    // sequencer state, round-robin pointer and per-port read capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLR_ON_RESET ? CLEAR : SERVE;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            clr_done_q  <= clearing && clr_cnt_q == '1;
            p0_rvalid_q <= gnt[0] && !p0_we;
            p1_rvalid_q <= gnt[1] && !p1_we;
            if (gnt[0] && !p0_we) p0_rdata_q <= mem_dat_out;
            if (gnt[1] && !p1_we) p1_rdata_q <= mem_dat_out;
            rr_ptr_q <= rr_ptr_d;
            if (clearing) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) state_q <= SERVE;
            end else if (start) begin
                state_q <= CLEAR;
            end
        end
    end

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign busy      = clearing;
    assign clr_done  = clr_done_q;
endmodule

// File: doc/dat_mem_arb.md
Name: dat_mem_arb

Overview:
- Controller/arbiter in front of the 8-bit x 256 single-port data memory. Shares the memory between two requesters: port 0 (processor load/store) and port 1 (host/loader).
- Contains a clear sequencer that zeroes all words. The memory's own bulk reset is therefore not needed for initialization.
- Sits between the requesters and the memory and is the only block that drives memory address, write enable and write data.

Parameters:
- AW, 8, address width; memory depth is 2**AW words.
- DW, 8, data width.
- CLR_ON_RESET, 1, when 1 a clear sweep starts automatically after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; requests a full clear sweep.
- p0_req  input  1  port 0 access request; held until granted.
- p0_we  input  1  port 0: 1 = write, 0 = read.
- p0_addr  input  AW  port 0 address.
- p0_wdata  input  DW  port 0 write data.
- p0_gnt  output  1  port 0 granted this cycle (combinational).
- p0_rdata  output  DW  port 0 registered read data.
- p0_rvalid  output  1  port 0 read data valid, one-cycle pulse.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rdata, p1_rvalid: same as port 0, for port 1.
- mem_wr_en  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_dat_in  output  DW  memory write data.
- mem_dat_out  input  DW  memory combinational read data.
- busy  output  1  high while in CLEAR.
- clr_done  output  1  one-cycle pulse after the last clear write.

Behaviour:
- State machine: CLEAR and SERVE. Registered state: state, clr_cnt[AW-1:0], rr_ptr (1 bit), per-port rdata and rvalid.
- Reset values:
  - state = CLEAR if CLR_ON_RESET, else SERVE.
  - clr_cnt = 0, rr_ptr = 0 (port 0 favoured).
  - p0_rdata, p1_rdata, p0_rvalid, p1_rvalid, clr_done all = 0.
  - busy follows state.
- CLEAR:
  - mem_wr_en = 1, mem_addr = clr_cnt, mem_dat_in = 0.
  - clr_cnt increments each cycle. When clr_cnt == 2**AW-1, go to SERVE, reset clr_cnt to 0, and pulse clr_done in the next cycle.
  - A sweep lasts exactly 2**AW cycles (256 at default).
  - p0_gnt = p1_gnt = 0; requests wait. start is ignored.
- SERVE, start = 1:
  - Go to CLEAR next cycle. No grant in the start cycle; start has priority over requests.
  - Memory outputs are idle that cycle: mem_wr_en = 0, mem_addr = 0, mem_dat_in = 0.
- SERVE, no start — arbitration:
  - If exactly one port requests, that port is granted.
  - If both request, the port selected by rr_ptr is granted.
  - On any grant, rr_ptr is set to the other port.
  - At most one grant per cycle.
- Granted access (same cycle):
  - mem_addr = granted addr, mem_wr_en = granted we, mem_dat_in = granted wdata.
  - Write: completes at that clock edge.
  - Read: mem_dat_out is captured into that port's rdata at the edge, and its rvalid is high for exactly the following cycle.
- No grant in SERVE: mem_wr_en = 0, mem_addr = 0, mem_dat_in = 0.
- rdata holds its last value until the next read grant to that port. Writes never assert rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data.
- A requester may change addr/we/wdata, or drop req, after each granted cycle. Each granted cycle is one complete access.
- Reset mid-sweep or mid-access: all state returns to reset values immediately (asynchronous); the in-flight access is discarded. Deasserting reset with CLR_ON_RESET = 1 restarts the sweep at address 0.
- Address counter is exactly AW bits; no out-of-range access is possible.

Decomposition:
- Shared package dat_mem_pkg:
  - constants AW, DW, DEPTH;
  - enum arb_state_t {CLEAR, SERVE};
  - struct mem_req_t {req, we, addr, wdata}.
- One natural sub-module: rr_arb2, a 2-input round-robin picker.
  - Inputs: req[1:0], ptr.
  - Outputs: gnt[1:0], next_ptr.
  - Combinational; the pointer register stays in the parent.
- Memory is external and instantiated alongside at the next level up.

Test Plan:
- Reset with CLR_ON_RESET = 1, memory preloaded with 0xA5 -> busy for 256 cycles; mem_wr_en = 1 with addresses 0..255 in order; clr_done pulses once; every word reads 0x00 afterwards.
- SERVE, port 0 writes 0x3C to addr 0x10, then reads 0x10 next cycle -> p0_gnt both cycles; p0_rvalid one cycle later with p0_rdata = 0x3C; p1 signals unchanged.
- Both ports continuously request reads (p0 addr 0x01 = 0x11, p1 addr 0x02 = 0x22) -> grants alternate p0, p1, p0, p1; each rvalid pulses with the matching data.
- start pulse while p1_req is held -> no grant that cycle; 256-cycle sweep; p1 granted in the first cycle after busy falls.
- reset asserted at sweep address 0x80 -> outputs reset immediately; after release the sweep restarts at 0x00 and runs the full 256 cycles.
- Port 1 write 0xFF to 0xFF and port 0 read 0xFF requested together with rr_ptr = 1 -> p1 granted first, p0 granted next cycle, p0_rdata = 0xFF.
